// File: rtl/guess_entry_display_if.sv
// Keypad/button inputs and multiplexed display/guess outputs of the guess entry block.
// The master side drives the keypad and buttons; the slave side is the entry logic.
`timescale 1ns/1ps

interface guess_entry_display_if #(
   parameter int NUM_DIGITS = 4
);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   logic [3:0]              key_val;
   logic                    btn_del;
   logic                    btn_enter;
   logic [NUM_DIGITS-1:0]   anode;
   logic [3:0]              hex_out;
   logic [4*NUM_DIGITS-1:0] guess;
   logic                    guess_valid;
   logic [CW-1:0]           cursor;

   modport master (
      output key_val, btn_del, btn_enter,
      input  anode, hex_out, guess, guess_valid, cursor
   );

   modport slave (
      input  key_val, btn_del, btn_enter,
      output anode, hex_out, guess, guess_valid, cursor
   );
endinterface

// File: rtl/guess_entry_display.sv
// Guess entry: keypad digits into slots, delete/enter buttons, locked submit, multiplexed display scan.
// Latency: key 1 cycle, buttons act on 3rd edge after raw rise, display 1 cycle; no backpressure, inapplicable events dropped.
`timescale 1ns/1ps

module guess_entry_display #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   guess_entry_display_if.slave bus
);
   localparam int CW = $clog2(NUM_DIGITS + 1);
   localparam int SW = $clog2(NUM_DIGITS);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] FULL  = CW'(NUM_DIGITS);
   localparam logic [3:0]    BLANK = 4'hF;

   typedef enum logic {ENTRY = 1'b0, LOCKED = 1'b1} state_t;

   state_t                      state, state_nxt;
   logic [NUM_DIGITS-1:0][3:0]  slots, slots_nxt;
   logic [CW-1:0]               cursor, cursor_nxt;
   logic                        guess_valid_r, valid_nxt;

   logic del_s1, del_s2, del_prev;
   logic ent_s1, ent_s2, ent_prev;
   logic [1:0] settle;
   logic btns_live;
   logic del_evt, ent_evt, key_evt;
   logic [3:0] key_prev;

   logic [RW-1:0]         refresh_cnt;
   logic [SW-1:0]         scan_idx;
   logic [3:0]            lit_code, hex_nxt, hex_r;
   logic [NUM_DIGITS-1:0] anode_nxt, anode_r;

   // Edges are masked until the synchronisers have flushed after reset, so a
   // button already held at reset release needs a fresh press.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         del_s1   <= 1'b0;
         del_s2   <= 1'b0;
         del_prev <= 1'b0;
         ent_s1   <= 1'b0;
         ent_s2   <= 1'b0;
         ent_prev <= 1'b0;
         settle   <= 2'd0;
      end else begin
         del_s1   <= bus.btn_del;
         del_s2   <= del_s1;
         del_prev <= del_s2;
         ent_s1   <= bus.btn_enter;
         ent_s2   <= ent_s1;
         ent_prev <= ent_s2;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   assign btns_live = (settle == 2'd3);
   assign del_evt   = del_s2 & ~del_prev & btns_live;
   assign ent_evt   = ent_s2 & ~ent_prev & btns_live;

   // Codes A-E leave the history untouched so they never read as a release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         key_prev <= BLANK;
      else if (bus.key_val <= 4'd9 || bus.key_val == BLANK)
         key_prev <= bus.key_val;
   end

   assign key_evt = (bus.key_val <= 4'd9) && (key_prev == BLANK);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ENTRY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ENTRY:   if (!del_evt && ent_evt && cursor == FULL) state_nxt = LOCKED;
         LOCKED:  if (del_evt) state_nxt = ENTRY;
         default: state_nxt = ENTRY;
      endcase
   end

   always_comb begin
      slots_nxt  = slots;
      cursor_nxt = cursor;
      valid_nxt  = 1'b0;
      case (state)
         ENTRY: begin
            if (del_evt) begin
               if (cursor != '0) begin
                  for (int i = 0; i < NUM_DIGITS; i++)
                     if (CW'(i) == cursor - 1'b1) slots_nxt[i] = BLANK;
                  cursor_nxt = cursor - 1'b1;
               end
            end else if (ent_evt) begin
               if (cursor == FULL) valid_nxt = 1'b1;
            end else if (key_evt && cursor != FULL) begin
               for (int i = 0; i < NUM_DIGITS; i++)
                  if (CW'(i) == cursor) slots_nxt[i] = bus.key_val;
               cursor_nxt = cursor + 1'b1;
            end
         end
         LOCKED: begin
            if (del_evt) begin
               slots_nxt  = '1;
               cursor_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         slots         <= '1;
         cursor        <= '0;
         guess_valid_r <= 1'b0;
      end else begin
         slots         <= slots_nxt;
         cursor        <= cursor_nxt;
         guess_valid_r <= valid_nxt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         refresh_cnt <= '0;
         scan_idx    <= '0;
      end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
         refresh_cnt <= '0;
         scan_idx    <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Slot 0 drives the leftmost (MSB) anode; blank slots keep every anode off.
   always_comb begin
      lit_code  = slots[scan_idx];
      hex_nxt   = lit_code;
      anode_nxt = '1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (lit_code != BLANK && scan_idx == SW'(i)) anode_nxt[NUM_DIGITS-1-i] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         anode_r <= '1;
         hex_r   <= BLANK;
      end else begin
         anode_r <= anode_nxt;
         hex_r   <= hex_nxt;
      end
   end

   assign bus.anode       = anode_r;
   assign bus.hex_out     = hex_r;
   assign bus.guess       = slots;
   assign bus.guess_valid = guess_valid_r;
   assign bus.cursor      = cursor;
endmodule

// File: tb/tb_guess_entry_display.sv
// Directed bench for guess_entry_display (4 digits, 4-cycle refresh) with an expectation queue.
`timescale 1ns/1ps

module tb_guess_entry_display;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   int   gv_seen     = 0;

   typedef struct {
      string       tag;
      logic [2:0]  cur;
      logic [15:0] gss;
      int          gv;
   } exp_t;

   exp_t sb[$];

   guess_entry_display_if #(.NUM_DIGITS(4)) bus ();

   guess_entry_display #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (reset_n) cyc <= cyc + 1;
      else         cyc <= 0;
      if (bus.guess_valid === 1'b1) gv_seen <= gv_seen + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input string tag, input int c, input logic [15:0] g, input int gv);
      exp_t e;
      e.tag = tag;
      e.cur = 3'(c);
      e.gss = g;
      e.gv  = gv;
      sb.push_back(e);
   endtask

   task automatic pop_chk();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({e.tag, "_cursor"}, 32'(bus.cursor), 32'(e.cur));
         chk({e.tag, "_guess"},  32'(bus.guess),  32'(e.gss));
         chk({e.tag, "_gv"},     32'(gv_seen),    32'(e.gv));
      end
   endtask

   task automatic key(input string tag, input logic [3:0] k, input int c, input logic [15:0] g, input int gv);
      push_exp(tag, c, g, gv);
      bus.key_val = k;
      tick(2);
      bus.key_val = 4'hF;
      tick(2);
      pop_chk();
   endtask

   // which: 0 = delete, 1 = enter, 2 = both in the same cycle
   task automatic btn(input string tag, input int which, input int c, input logic [15:0] g, input int gv);
      push_exp(tag, c, g, gv);
      bus.btn_del   = (which != 1);
      bus.btn_enter = (which != 0);
      tick(5);
      bus.btn_del   = 1'b0;
      bus.btn_enter = 1'b0;
      tick(3);
      pop_chk();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_anode"},  32'(bus.anode),       32'hF);
      chk({tag, "_hex"},    32'(bus.hex_out),     32'hF);
      chk({tag, "_guess"},  32'(bus.guess),       32'hFFFF);
      chk({tag, "_cursor"}, 32'(bus.cursor),      32'd0);
      chk({tag, "_gvout"},  32'(bus.guess_valid), 32'd0);
   endtask

   initial begin
      int idx;
      logic [3:0] ea, eh;
      bus.key_val   = 4'hF;
      bus.btn_del   = 1'b0;
      bus.btn_enter = 1'b0;
      tick(3);
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      tick(4);

      // four digits fill the guess; a fifth is ignored
      key("k1", 4'h1, 1, 16'hFFF1, 0);
      key("k2", 4'h2, 2, 16'hFF21, 0);
      key("k3", 4'h3, 3, 16'hF321, 0);
      key("k4", 4'h4, 4, 16'h4321, 0);
      key("k5_full", 4'h7, 4, 16'h4321, 0);
      key("kA_ign", 4'hA, 4, 16'h4321, 0);

      // enter with three digits is ignored and entry continues
      btn("del_to3", 0, 3, 16'hF321, 0);
      btn("ent_c3", 1, 3, 16'hF321, 0);
      key("k4_again", 4'h4, 4, 16'h4321, 0);
      btn("del_a", 0, 3, 16'hF321, 0);
      btn("del_b", 0, 2, 16'hFF21, 0);
      btn("del_c", 0, 1, 16'hFFF1, 0);
      btn("del_d", 0, 0, 16'hFFFF, 0);
      btn("del_under", 0, 0, 16'hFFFF, 0);

      // submit, locked behaviour, unlock by delete
      key("g9", 4'h9, 1, 16'hFFF9, 0);
      key("g8", 4'h8, 2, 16'hFF89, 0);
      key("g7", 4'h7, 3, 16'hF789, 0);
      key("g6", 4'h6, 4, 16'h6789, 0);
      btn("submit", 1, 4, 16'h6789, 1);
      key("lock_key", 4'h5, 4, 16'h6789, 1);
      btn("lock_ent", 1, 4, 16'h6789, 1);
      btn("unlock", 0, 0, 16'hFFFF, 1);
      key("entry_key", 4'h3, 1, 16'hFFF3, 1);
      btn("clr", 0, 0, 16'hFFFF, 1);

      key("k5", 4'h5, 1, 16'hFFF5, 1);
      key("k6", 4'h6, 2, 16'hFF65, 1);
      btn("del1", 0, 1, 16'hFFF5, 1);
      btn("del2", 0, 0, 16'hFFFF, 1);
      btn("del3", 0, 0, 16'hFFFF, 1);

      // display scan of FF21
      key("s1", 4'h1, 1, 16'hFFF1, 1);
      key("s2", 4'h2, 2, 16'hFF21, 1);
      tick(2);
      for (int n = 0; n < 32; n++) begin
         idx = ((cyc - 1) / 4) % 4;
         case (idx)
            0:       begin ea = 4'b0111; eh = 4'h1; end
            1:       begin ea = 4'b1011; eh = 4'h2; end
            default: begin ea = 4'b1111; eh = 4'hF; end
         endcase
         chk("scan_anode", 32'(bus.anode), 32'(ea));
         chk("scan_hex",   32'(bus.hex_out), 32'(eh));
         tick(1);
      end

      // delete wins over enter in the same cycle
      key("s3", 4'h3, 3, 16'hF321, 1);
      key("s4", 4'h4, 4, 16'h4321, 1);
      btn("both", 2, 3, 16'hF321, 1);

      // asynchronous reset mid-entry, with delete held through it
      #2;
      reset_n = 1'b0;
      bus.btn_del = 1'b1;
      #1;
      chk_reset_outputs("async_rst");
      tick(3);
      reset_n = 1'b1;
      bus.key_val = 4'h5;
      tick(2);
      bus.key_val = 4'hF;
      push_exp("held_del", 1, 16'hFFF5, 1);
      tick(6);
      pop_chk();
      bus.btn_del = 1'b0;
      tick(3);
      btn("repress", 0, 0, 16'hFFFF, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/guess_entry_display.md
GUESS_ENTRY_DISPLAY -- requirements
Module: guess_entry_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4, legal 2..8: number of digit slots and display anodes.
REQ-002 Parameter REFRESH_DIV, default 100000, legal >= 2: clock cycles each digit is lit per scan step.
REQ-003 Localparam CW = $clog2(NUM_DIGITS+1): cursor width.
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 key_val  in  4  keypad code, synchronous to clock; 4'h0-4'h9 digit held, 4'hF no key, 4'hA-4'hE ignored.
REQ-007 btn_del  in  1  raw asynchronous delete/clear button, active-high.
REQ-008 btn_enter  in  1  raw asynchronous submit button, active-high.
REQ-009 anode  out  NUM_DIGITS  active-low digit enables, registered.
REQ-010 hex_out  out  4  code of lit digit, registered.
REQ-011 guess  out  4*NUM_DIGITS  slot i on bits [4i+3:4i]; slot 0 is the first digit entered.
REQ-012 guess_valid  out  1  one-cycle pulse when a full guess is submitted.
REQ-013 cursor  out  CW  number of filled slots, 0..NUM_DIGITS.

Function
REQ-014 Each slot holds 4'h0-4'h9 or blank 4'hF; guess continuously reflects slot registers.
REQ-015 btn_del and btn_enter each pass through a 2-flop synchroniser, then a registered rising-edge detector; the action updates state on the 3rd rising clock edge after the raw input rises (setup met); one action per press.
REQ-016 Key event: key_val in 0..9 in the current cycle while the previously registered key_val was 4'hF; codes A-E neither create events nor count as release; a held key yields exactly one event.
REQ-017 FSM states ENTRY and LOCKED; reset state ENTRY.
REQ-018 ENTRY, key event, cursor < NUM_DIGITS: slot[cursor] <= key, cursor <= cursor+1.
REQ-019 ENTRY, key event, cursor == NUM_DIGITS: ignored (full).
REQ-020 ENTRY, delete edge, cursor > 0: slot[cursor-1] <= 4'hF, cursor <= cursor-1; cursor == 0: no effect.
REQ-021 ENTRY, enter edge, cursor == NUM_DIGITS: guess_valid = 1 for exactly the next cycle, go LOCKED; cursor < NUM_DIGITS: ignored.
REQ-022 LOCKED: key events and enter edges ignored; slots held; delete edge sets all slots 4'hF, cursor 0, returns ENTRY.
REQ-023 Same-cycle priority: delete > enter > key event; lower-priority events in that cycle are dropped, not queued.
REQ-024 Refresh counter counts 0..REFRESH_DIV-1 and wraps; scan index (0..NUM_DIGITS-1) increments at wrap, wraps NUM_DIGITS-1 -> 0.
REQ-025 Scan index i, slot i != 4'hF: anode bit (NUM_DIGITS-1-i) low, others high, hex_out = slot i; slot 0 on leftmost anode.
REQ-026 Scan index i, slot i == 4'hF: anode all ones, hex_out = 4'hF.
REQ-027 anode/hex_out are registered from current scan index and slot values; a slot change is visible at most one cycle later while that slot is scanned.

Reset
REQ-028 reset_n low asynchronously forces: all slots 4'hF, cursor 0, state ENTRY, refresh counter and scan index 0, synchroniser/edge/key-history flops to 0 / 4'hF, anode all ones, hex_out 4'hF, guess_valid 0.
REQ-029 Reset mid-entry or in LOCKED discards the partial/locked guess; no guess_valid pulse on or after release.
REQ-030 After reset_n deasserts, a button already held high produces no action until released and pressed again.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-031 Keys 1,2,3,4 each pressed/released -> cursor 4, guess 16'h4321; 5th key 7 -> guess unchanged.
REQ-032 Keys 5,6 then btn_del -> cursor 1, guess 16'hFFF5; btn_del twice more -> cursor 0, guess 16'hFFFF, no underflow.
REQ-033 Guess 9,8,7,6 then btn_enter -> single guess_valid pulse, state LOCKED; further keys/enter ignored; btn_del -> guess 16'hFFFF, cursor 0, ENTRY.
REQ-034 btn_enter with cursor 3 -> no guess_valid, state ENTRY, guess unchanged.
REQ-035 Guess 16'hFF21 scanned -> anode 0111/hex 1, 1011/hex 2, then 1111/hex F for two steps, each step 4 cycles, repeating.
REQ-036 btn_del and btn_enter rising same cycle with cursor 4 -> delete applied (cursor 3), no guess_valid; reset_n pulsed low mid-entry -> outputs at REQ-028 values immediately.
